regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
Write-side driver for the 32-entry register file. It merges single-cycle ALU results with variable-latency load results and drives the register file's single write port (write enable, write address, write data), issuing at most one write per cycle. Load results wait in a small FIFO behind a valid/ready handshake; ALU results have priority, with a starvation limit that stalls the ALU. An optional pending-destination mask lets the hazard logic see buffered writes.

Parameters:
- WIDTH, 32, data width of the write port and of both result sources.
- DEPTH, 2, load-result FIFO entries; power of two, minimum 2.
- STARVE_MAX, 4, consecutive ALU-won cycles with a non-empty FIFO before the ALU is stalled; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  ALU result is accepted this cycle; upstream holds its result while low.
- alu_rd  in  5  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  FIFO can accept a load result.
- mem_rd  in  5  load destination register.
- mem_data  in  WIDTH  load result.
- reg_write  out  1  register-file write enable.
- w1  out  5  register-file write address.
- wd1  out  WIDTH  register-file write data.
- pending  out  32  destination-register bitmap of buffered load results; bit 0 is always 0.

Behaviour:
- Reset (asynchronous): reg_write=0, w1=0, wd1=0, FIFO empty, starve_cnt=0, pending=0. While rst is high, alu_ready=0 and mem_ready=0.
- Load handshake: mem_ready is the negation of FIFO-full. A push happens when mem_valid and mem_ready are both high.
  - There is no same-cycle pass-through. When full, mem_ready stays 0 even if a pop occurs this cycle.
  - mem_rd and mem_data must hold while mem_valid=1 and mem_ready=0.
- Issue arbitration, evaluated each cycle; the winner is registered into reg_write/w1/wd1 at the next edge:
  - STALL: if starve_cnt==STARVE_MAX and the FIFO is non-empty, then alu_ready=0, pop the FIFO head and issue it, and clear starve_cnt.
  - ALU: otherwise alu_ready=1. If alu_valid=1, issue the ALU result. If the FIFO is also non-empty, starve_cnt increments, saturating at STARVE_MAX.
  - FIFO: otherwise, if the FIFO is non-empty, pop and issue the head, and clear starve_cnt.
  - IDLE: otherwise reg_write=0, and w1/wd1 hold their values.
- Latency:
  - ALU result to reg_write high: 1 cycle.
  - Load result to reg_write high: minimum 2 cycles (push, then pop).
  - The register file captures the write one edge after reg_write is high.
- x0 suppression: an issued entry with rd==0 is consumed (popped or acknowledged) but drives reg_write=0. w1 and wd1 hold their values.
- A push and a pop in the same cycle keep the count unchanged. Read and write pointers wrap modulo DEPTH.
- Ordering: ALU and load writes to the same rd retire in issue order with no reordering or merging. WAW resolution belongs to the hazard unit, which uses pending.
- starve_cnt clears whenever the FIFO is empty.
- Reset asserted mid-operation flushes buffered entries. No write is issued during reset or in the first cycle after reset.

Optional Feature:
- Macro: REGFILE_WB_PENDING_EN.
- Defined: pending is the OR of one-hot(rd) over the valid FIFO entries, excluding rd==0. It is combinational from FIFO state and updates the cycle after a push or pop.
- Undefined: pending is tied to 0, and no per-entry decode logic is built.

Decomposition:
- Shared package/include `regfile_pkg`:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - The write-entry record (rd plus data), with width REG_ADDR_W+WIDTH.
  - Issue-source encoding: IDLE/ALU/FIFO/STALL.
- Sub-module `wb_fifo`: a parameterized synchronous FIFO (DEPTH, entry width) with full/empty/count outputs and an entry-valid vector for the pending decode.
- Arbitration, the starve counter, the output register and x0 suppression stay in the top module.

Test Plan:
- Single ALU write:
  - After reset, alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle.
  - Next cycle: reg_write=1, w1=5, wd1=0xDEADBEEF.
  - Following cycle: reg_write=0.
- Load path:
  - mem_valid=1, mem_rd=7, mem_data=0x12345678, with ALU idle.
  - reg_write=1 with w1=7 exactly 2 cycles after acceptance.
  - pending[7]=1 for the intervening cycle (macro defined).
- Full FIFO:
  - DEPTH=2, alu_valid held at 1, three loads offered.
  - Two accepted; mem_ready=0 for the third until a pop.
  - alu_ready drops once after 4 ALU-won cycles, and w1 then shows the first load's rd.
- x0 discard:
  - ALU with alu_rd=0 and data 0xFFFFFFFF, then a load with rd=0.
  - Both consumed; reg_write stays 0; the FIFO drains to empty.
- Reset mid-operation:
  - Two loads buffered, assert rst asynchronously between edges.
  - reg_write=0, pending=0 and mem_ready=0 immediately.
  - After release: mem_ready=1 and no stale writes appear.
- Back-to-back mix:
  - Alternating ALU (rd=1..4) and loads (rd=10..13) at 1 per cycle.
  - Every write appears exactly once, per-source order is preserved, and there are no lost or duplicated writes (scoreboard check).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path: address widths,
// the buffered write-entry record and the issue-source encoding.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int WB_DATA_W  = 32;

   // Buffered entries are packed as {rd, data}; rd sits in the top bits.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0]  data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SRC_IDLE  = 2'd0,
      SRC_ALU   = 2'd1,
      SRC_FIFO  = 2'd2,
      SRC_STALL = 2'd3
   } issue_src_e;

   function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
      logic [NUM_REGS-1:0] oh;
      oh = '0;
      if (rd != '0) begin
         oh[rd] = 1'b1;
      end else begin
         oh = '0;
      end
      return oh;
   endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Small synchronous FIFO holding load results awaiting a write-port slot.
// With REGFILE_WB_PENDING_EN it also exposes its storage and per-slot valid bits.
module wb_fifo #(
   parameter  int DEPTH = 2,
   parameter  int EW    = 37,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [EW-1:0] wdata_i,
   output logic [EW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
`ifdef REGFILE_WB_PENDING_EN
   ,
   output logic [DEPTH-1:0]         valid_o,
   output logic [DEPTH-1:0][EW-1:0] mem_o
`endif
);

   logic [DEPTH-1:0][EW-1:0] mem_q;
   logic [AW-1:0]            wr_ptr_q;
   logic [AW-1:0]            rd_ptr_q;
   logic [AW:0]              cnt_q;
   logic                     push_s;
   logic                     pop_s;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_s  = push_i && !full_o;
   assign pop_s   = pop_i && !empty_o;

   // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

`ifdef REGFILE_WB_PENDING_EN
   assign mem_o = mem_q;

   // A slot is live when its distance from the read pointer is below the occupancy
   always_comb begin
      valid_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_o[i] = ({1'b0, AW'(i) - rd_ptr_q} < cnt_q);
      end
   end
`endif

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port driver merging ALU and buffered load results.
// Optional feature macro: REGFILE_WB_PENDING_EN (pending destination bitmap).
module regfile_writeback
   import regfile_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [WIDTH-1:0]      alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [WIDTH-1:0]      mem_data,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] w1,
   output logic [WIDTH-1:0]      wd1,
   output logic [NUM_REGS-1:0]   pending
);

   localparam int EW = REG_ADDR_W + WIDTH;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [EW-1:0]         fifo_rdata_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic [CW-1:0]         fifo_cnt_s;
   logic                  push_s;
   logic                  pop_s;
   issue_src_e            src_s;
   logic                  iss_vld_s;
   logic [REG_ADDR_W-1:0] iss_rd_s;
   logic [WIDTH-1:0]      iss_data_s;
   logic [3:0]            starve_q, starve_d;
   logic                  reg_write_q, reg_write_d;
   logic [REG_ADDR_W-1:0] w1_q, w1_d;
   logic [WIDTH-1:0]      wd1_q, wd1_d;

   // No same-cycle pass-through: readiness depends only on stored occupancy
   assign mem_ready = !rst && !fifo_full_s;
   assign push_s    = mem_valid && mem_ready;
   assign pop_s     = (src_s == SRC_FIFO) || (src_s == SRC_STALL);

`ifdef REGFILE_WB_PENDING_EN
   logic [DEPTH-1:0]         fifo_vld_s;
   logic [DEPTH-1:0][EW-1:0] fifo_mem_s;
`endif

   wb_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i ({mem_rd, mem_data}),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_cnt_s)
`ifdef REGFILE_WB_PENDING_EN
      ,
      .valid_o (fifo_vld_s),
      .mem_o   (fifo_mem_s)
`endif
   );

   // Arbitration: ALU has priority until loads have waited STARVE_MAX ALU wins
   always_comb begin
      src_s     = SRC_IDLE;
      alu_ready = 1'b0;
      starve_d  = starve_q;
      if (rst) begin
         src_s    = SRC_IDLE;
         starve_d = '0;
      end else if ((starve_q == 4'(STARVE_MAX)) && !fifo_empty_s) begin
         src_s    = SRC_STALL;
         starve_d = '0;
      end else begin
         alu_ready = 1'b1;
         if (alu_valid) begin
            src_s = SRC_ALU;
            if (fifo_cnt_s == '0) begin
               starve_d = '0;
            end else if (starve_q < 4'(STARVE_MAX)) begin
               starve_d = starve_q + 4'd1;
            end else begin
               starve_d = starve_q;
            end
         end else if (!fifo_empty_s) begin
            src_s    = SRC_FIFO;
            starve_d = '0;
         end else begin
            src_s    = SRC_IDLE;
            starve_d = '0;
         end
      end
   end

   // Select the winner's payload; writes to x0 are consumed but never driven
   always_comb begin
      iss_vld_s   = 1'b0;
      iss_rd_s    = '0;
      iss_data_s  = '0;
      case (src_s)
         SRC_ALU: begin
            iss_vld_s  = 1'b1;
            iss_rd_s   = alu_rd;
            iss_data_s = alu_data;
         end
         SRC_FIFO, SRC_STALL: begin
            iss_vld_s  = 1'b1;
            iss_rd_s   = fifo_rdata_s[EW-1:WIDTH];
            iss_data_s = fifo_rdata_s[WIDTH-1:0];
         end
         default: begin
            iss_vld_s = 1'b0;
         end
      endcase
      reg_write_d = 1'b0;
      w1_d        = w1_q;
      wd1_d       = wd1_q;
      if (iss_vld_s && (iss_rd_s != '0)) begin
         reg_write_d = 1'b1;
         w1_d        = iss_rd_s;
         wd1_d       = iss_data_s;
      end else begin
         reg_write_d = 1'b0;
      end
   end

   // Registered write port and starvation counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_q <= 1'b0;
         w1_q        <= '0;
         wd1_q       <= '0;
         starve_q    <= '0;
      end else begin
         reg_write_q <= reg_write_d;
         w1_q        <= w1_d;
         wd1_q       <= wd1_d;
         starve_q    <= starve_d;
      end
   end

   assign reg_write = reg_write_q;
   assign w1        = w1_q;
   assign wd1       = wd1_q;

`ifdef REGFILE_WB_PENDING_EN
   // Destinations of every live buffered load, x0 excluded by rd_onehot
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_vld_s[i]) begin
            pending = pending | rd_onehot(fifo_mem_s[i][EW-1:WIDTH]);
         end else begin
            pending = pending;
         end
      end
   end
`else
   assign pending = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed table, corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_regfile_writeback;

   localparam int DEPTH = 2;
   localparam int SMAX  = 4;

   logic        clk, rst;
   logic        alu_valid, alu_ready, mem_valid, mem_ready, reg_write;
   logic [4:0]  alu_rd, mem_rd, w1;
   logic [31:0] alu_data, mem_data, wd1, pending;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   // reference model state
   ent_t        mq[$];
   int          m_starve;
   logic        m_rw;
   logic [4:0]  m_w1;
   logic [31:0] m_wd1;
   ent_t        dut_log[$];

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] md;
      logic        rw;
      logic [4:0]  w1;
      logic [31:0] wd1;
      logic [31:0] pend;
   } vec_t;

   vec_t tbl[8];

   regfile_writeback #(.WIDTH(32), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .reg_write(reg_write), .w1(w1), .wd1(wd1), .pending(pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_pend();
      logic [31:0] p;
      p = 32'h0;
`ifdef REGFILE_WB_PENDING_EN
      foreach (mq[i]) if (mq[i].rd != 5'd0) p[mq[i].rd] = 1'b1;
`endif
      return p;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_starve = 0;
      m_rw = 1'b0;
      m_w1 = 5'd0;
      m_wd1 = 32'h0;
   endtask

   // One clock: drive inputs, check readies mid-cycle, step the model, check outputs after the edge
   task automatic run_cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                            input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                            output logic a_acc, output logic m_acc);
      logic e_ar, e_mr, stall, iss;
      ent_t e;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      @(negedge clk);
      e_mr  = (mq.size() < DEPTH);
      stall = (m_starve == SMAX) && (mq.size() != 0);
      e_ar  = !stall;
      chk("alu_ready", alu_ready, e_ar);
      chk("mem_ready", mem_ready, e_mr);
      iss = 1'b0;
      e = '0;
      if (stall) begin
         e = mq.pop_front(); iss = 1'b1; m_starve = 0;
      end else if (av) begin
         e = '{rd: ard, data: ad}; iss = 1'b1;
         if (mq.size() != 0) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
         else m_starve = 0;
      end else if (mq.size() != 0) begin
         e = mq.pop_front(); iss = 1'b1; m_starve = 0;
      end else begin
         m_starve = 0;
      end
      if (mv && e_mr) mq.push_back('{rd: mrd, data: md});
      a_acc = av && e_ar;
      m_acc = mv && e_mr;
      if (iss && e.rd != 5'd0) begin
         m_rw = 1'b1; m_w1 = e.rd; m_wd1 = e.data;
      end else begin
         m_rw = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("reg_write", reg_write, m_rw);
      chk("w1", w1, m_w1);
      chk("wd1", wd1, m_wd1);
      chk("pending", pending, model_pend());
      if (reg_write === 1'b1) dut_log.push_back('{rd: w1, data: wd1});
   endtask

   task automatic idle(input int n);
      logic a, m;
      for (int i = 0; i < n; i++) run_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, a, m);
   endtask

   initial begin
      logic aa, ma;
      int stall_c, rej_c, li, ai, idx, cyc;
      logic [4:0] rd_v;
      logic [31:0] d_v;
      logic        pa, pm;
      logic [4:0]  par, pmr;
      logic [31:0] pad, pmd;

      tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
      tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
      tbl[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h12345678, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
      tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h12345678, 32'h0};
      tbl[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h12345678, 32'h0};
      tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hAAAA5555, 1'b0, 5'd7, 32'h12345678, 32'h0};
      tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h12345678, 32'h0};
      tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h12345678, 32'h0};

      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
      mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_alu_ready", alu_ready, 1'b0);
      chk("rst_mem_ready", mem_ready, 1'b0);
      chk("rst_reg_write", reg_write, 1'b0);
      chk("rst_w1", w1, 5'd0);
      chk("rst_wd1", wd1, 32'h0);
      chk("rst_pending", pending, 32'h0);
      rst = 1'b0;
      #1;
      chk("post_rst_mem_ready", mem_ready, 1'b1);
      chk("post_rst_alu_ready", alu_ready, 1'b1);

      // directed table: single ALU write, load path, x0 discard
      for (int i = 0; i < 8; i++) begin
         logic [31:0] ep;
         run_cycle(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md, aa, ma);
`ifdef REGFILE_WB_PENDING_EN
         ep = tbl[i].pend;
`else
         ep = 32'h0;
`endif
         chk("tbl_reg_write", reg_write, tbl[i].rw);
         chk("tbl_w1", w1, tbl[i].w1);
         chk("tbl_wd1", wd1, tbl[i].wd1);
         chk("tbl_pending", pending, ep);
      end

      // full FIFO with a continuously busy ALU
      stall_c = -1; rej_c = -1; li = 0; ai = 1;
      for (int c = 0; c < 8; c++) begin
         run_cycle(1'b1, 5'(ai), 32'(ai) * 32'h11, (li < 3), 5'(20 + li), 32'(li) + 32'hC000, aa, ma);
         if (aa) ai++;
         if (ma) li++;
         if (!ma && li < 3 && rej_c < 0) rej_c = c;
         if (!aa && stall_c < 0) begin
            stall_c = c;
            chk("stall_reg_write", reg_write, 1'b1);
            chk("stall_w1", w1, 5'd20);
         end
      end
      chk("first_mem_reject", rej_c, 32'd2);
      chk("stall_cycle", stall_c, 32'd5);
      idle(8);

      // reset mid-operation with two buffered loads
      run_cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88, aa, ma);
      run_cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99, aa, ma);
      chk("mid_two_buffered", mem_ready, 1'b0);
      alu_valid = 1'b0; mem_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_reg_write", reg_write, 1'b0);
      chk("mid_rst_pending", pending, 32'h0);
      chk("mid_rst_mem_ready", mem_ready, 1'b0);
      chk("mid_rst_alu_ready", alu_ready, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      #1;
      chk("rel_mem_ready", mem_ready, 1'b1);
      chk("rel_reg_write", reg_write, 1'b0);
      dut_log.delete();
      idle(5);
      chk("no_stale_writes", dut_log.size(), 32'd0);

      // back-to-back alternating ALU / load mix, scoreboarded per source
      dut_log.delete();
      idx = 0; cyc = 0;
      while (idx < 8 && cyc < 40) begin
         if (idx % 2 == 0) begin
            rd_v = 5'(1 + idx / 2);
            d_v  = 32'(rd_v) * 32'h01010101;
            run_cycle(1'b1, rd_v, d_v, 1'b0, 5'd0, 32'h0, aa, ma);
            if (aa) idx++;
         end else begin
            rd_v = 5'(10 + idx / 2);
            d_v  = 32'(rd_v) * 32'h01010101;
            run_cycle(1'b0, 5'd0, 32'h0, 1'b1, rd_v, d_v, aa, ma);
            if (ma) idx++;
         end
         cyc++;
      end
      chk("mix_all_offered", idx, 32'd8);
      idle(6);
      ai = 0; li = 0;
      foreach (dut_log[k]) begin
         if (dut_log[k].rd < 5'd10) begin
            chk("mix_alu_order", dut_log[k].rd, 32'(1 + ai));
            chk("mix_alu_data", dut_log[k].data, 32'(1 + ai) * 32'h01010101);
            ai++;
         end else begin
            chk("mix_load_order", dut_log[k].rd, 32'(10 + li));
            chk("mix_load_data", dut_log[k].data, 32'(10 + li) * 32'h01010101);
            li++;
         end
      end
      chk("mix_alu_count", ai, 32'd4);
      chk("mix_load_count", li, 32'd4);

      // randomized traffic; offers are held until accepted
      pa = 1'b0; pm = 1'b0; par = 5'd0; pmr = 5'd0; pad = 32'h0; pmd = 32'h0;
      for (int c = 0; c < 1500; c++) begin
         if (!pa && $urandom_range(0, 99) < 60) begin
            pa = 1'b1; par = 5'($urandom_range(0, 31)); pad = $urandom;
         end
         if (!pm && $urandom_range(0, 99) < 45) begin
            pm = 1'b1; pmr = 5'($urandom_range(0, 31)); pmd = $urandom;
         end
         run_cycle(pa, par, pad, pm, pmr, pmd, aa, ma);
         if (aa) pa = 1'b0;
         if (ma) pm = 1'b0;
      end
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
